// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: byte/half/word loads and stores, one transaction at a time.
// Latency: LATENCY cycles from request accept to resp_valid, then at least one idle cycle before the next accept.
// Backpressure: req_ready drops while busy; the response is held stable until resp_ready. Macro DMEM_ERR_EN enables error detection.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Access decode (from the latched request)
  logic          sz_b, sz_h, sz_w, sext;
  logic [1:0]    lane;
  logic [AW-1:0] widx;
  logic          acc_err;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   rdata_nx;
  logic [3:0]    wmask;
  logic [31:0]   wlanes;
  logic          commit;
  logic          wr_en;

  // Accepting only in IDLE and never while reset is held keeps req_ready low during reset.
  assign req_ready = (state == S_IDLE) && !rst;

  // The access happens on the edge that leaves BUSY; reset on that edge cancels it.
  assign commit = (state == S_BUSY) && (cnt == 4'd0) && !rst;
  assign wr_en  = commit && we_q && !acc_err;

  // Decode size, lane, word index and error status of the pending access
  always_comb begin
    sz_b    = 1'b0;
    sz_h    = 1'b0;
    sz_w    = 1'b0;
    sext    = 1'b0;
    lane    = 2'b00;
    widx    = '0;
    acc_err = 1'b0;

    // BU/HU only exist for loads; any other code falls back to word size.
    sz_b = (f3_q == 3'b000) || ((f3_q == 3'b100) && !we_q);
    sz_h = (f3_q == 3'b001) || ((f3_q == 3'b101) && !we_q);
    sz_w = !sz_b && !sz_h;
    sext = !f3_q[2];

`ifdef DMEM_ERR_EN
    lane    = addr_q[1:0];
    widx    = addr_q[AW+1:2];
    acc_err = !((f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                (f3_q == 3'b100) || (f3_q == 3'b101))
              || (we_q && f3_q[2])
              || (sz_h && addr_q[0])
              || (sz_w && (addr_q[1:0] != 2'b00))
              || ({2'b00, addr_q[31:2]} >= DEPTH_U);
`else
    // Without error detection, misaligned accesses snap down to their size
    // and the word index wraps around the array.
    if (sz_w) begin
      lane = 2'b00;
    end else if (sz_h) begin
      lane = {addr_q[1], 1'b0};
    end else begin
      lane = addr_q[1:0];
    end
    widx    = AW'({2'b00, addr_q[31:2]} % DEPTH_U);
    acc_err = 1'b0;
`endif
  end

  // Select and extend the load data; stores and errors return zero
  always_comb begin
    rword    = mem[widx];
    rbyte    = rword[8*lane +: 8];
    rhalf    = lane[1] ? rword[31:16] : rword[15:0];
    rdata_nx = 32'd0;
    if (!acc_err && !we_q) begin
      if (sz_b) begin
        rdata_nx = {{24{sext & rbyte[7]}}, rbyte};
      end else if (sz_h) begin
        rdata_nx = {{16{sext & rhalf[15]}}, rhalf};
      end else begin
        rdata_nx = rword;
      end
    end
  end

  // Build the byte-lane enables and the replicated store data
  always_comb begin
    wmask  = 4'b0000;
    wlanes = wdata_q;
    if (sz_b) begin
      wmask  = 4'b0001 << lane;
      wlanes = {4{wdata_q[7:0]}};
    end else if (sz_h) begin
      wmask  = lane[1] ? 4'b1100 : 4'b0011;
      wlanes = {2{wdata_q[15:0]}};
    end else begin
      wmask  = 4'b1111;
      wlanes = wdata_q;
    end
  end

  // Memory array: byte-lane writes, contents are not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wmask[i]) begin
        mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // Request/latency/response state machine with registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      f3_q       <= 3'b000;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
            cnt     <= CNT_INIT;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt == 4'd0) begin
            resp_valid <= 1'b1;
            resp_rdata <= rdata_nx;
            resp_err   <= acc_err;
            state      <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
